gbar_arbiter: RTL and testbench
===============================

# gbar_arbiter

Arbitration and sequencing front-end for the global barrier unit. It collects global-barrier requests from `NUM_REQS` requesters (cores or clusters), grants one per cycle round-robin, and drives a single registered request stream into the barrier unit's slave bus. Each barrier release from the unit is broadcast back to every requester one cycle later. Per-requester pending state keeps each requester to at most one outstanding barrier.

## Interface
Parameters:
- `NUM_REQS`, 4: number of requesters; must be ≥ 2.
- `NB_WIDTH`, `` `NB_WIDTH ``: barrier id width.
- `NC_WIDTH`, `` `NC_WIDTH ``: core id / size_m1 width.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `req_valid`, in, `NUM_REQS`: per-requester request valid.
- `req_id`, in, `NUM_REQS`×`NB_WIDTH`: barrier id.
- `req_size_m1`, in, `NUM_REQS`×`NC_WIDTH`: participant count minus 1.
- `req_core_id`, in, `NUM_REQS`×`NC_WIDTH`: requesting core id.
- `req_ready`, out, `NUM_REQS`: per-requester accept.
- `rsp_valid`, out, 1: release broadcast, seen by all requesters.
- `rsp_id`, out, `NB_WIDTH`: released barrier id.
- `gbar_bus_if`, master, VX_gbar_bus_if: downstream request/response to the barrier unit.

## Operation
- **Pending mask.** `pending[i]` is set when requester i's request is accepted; `pending_id[i]` records `req_id`.
- **Eligibility.** Requester i is eligible when `req_valid[i] && !pending[i]`.
- **Grant.** Round-robin over eligible requesters, starting at `rr_ptr`. The pointer advances to (granted index + 1) mod `NUM_REQS`, and only on acceptance. With no acceptance the pointer holds.
- **Ready.** `req_ready[i]` = grant[i] && (!out_valid || `gbar_bus_if.req_ready`). At most one bit is set per cycle. `req_ready` is never asserted for a pending requester.
- **Output stage.** One register holds `out_valid` and the id/size_m1/core_id payload.
  - It loads on acceptance.
  - It clears when `gbar_bus_if.req_ready` is high and nothing new is accepted.
  - Payload is held stable while out_valid && !ready.
- **Response stage.** `gbar_bus_if.rsp_valid` and `rsp_data.id` are registered into `rsp_valid`/`rsp_id`. There is no backpressure on responses.
- **Pending clear.** On a registered broadcast, every i with `pending[i] && pending_id[i]==rsp_id` clears `pending[i]`. Multiple requesters may clear in the same cycle.
- **Simultaneous events.**
  - A clear and a re-request on the same requester in the same cycle: the clear wins. The request is accepted no earlier than the next cycle, because eligibility uses registered pending.
  - A response arriving with no matching pending requester is still broadcast; pending state is unchanged.
- **Protocol error.** A response whose id matches no request sent is not flagged and is not checked.

## Timing
- **Reset values.**
  - `req_ready` = 0 and `rsp_valid` = 0.
  - `rsp_id` = 0 and `out_valid` = 0.
  - `pending` = 0 and `rr_ptr` = 0.
- **Request latency.** Accept in cycle N gives `gbar_bus_if.req_valid` in N+1, with sustained throughput of 1 request/cycle.
- **Response latency.** Unit release in cycle M gives `rsp_valid` in M+1 and `pending` clear in M+1. Requester i can be re-accepted in M+2 at the earliest.
- **Reset mid-operation.** All pending and in-flight state is dropped. An in-flight output request is lost. Upstream cores must be reset together.
- **Downstream stall.** While `gbar_bus_if.req_ready`=0 and out_valid=1, all `req_ready` are 0.

## Structure
- **Shared package.**
  - `gbar_req_t` {id, size_m1, core_id} and `gbar_rsp_t` {id}, both already carried by VX_gbar_bus_if.
  - `` `NB_WIDTH `` and `` `NC_WIDTH `` from VX_define.vh.
- **Sub-module.** `gbar_rr_arbiter`: a parameterised round-robin grant with a one-hot output and an `advance` input. This is the only natural sub-module.
- **Inline logic.** The output register, response register and pending logic stay inline.

## Test plan
- **Round-robin fairness.** All 4 requesters valid from reset (ids 0–3), downstream ready → grants in order 0,1,2,3, one per cycle. Downstream req_valid runs from cycle 1 to cycle 4.
- **Pending block and release.** Requester 2 is accepted with id=5 and keeps req_valid high → req_ready[2] stays 0. Inject unit rsp id=5 in cycle M → rsp_valid and rsp_id=5 in M+1. Requester 2 is re-accepted in M+2.
- **Multi-clear.** Requesters 0 and 3 are pending on id=1 and requester 1 is pending on id=2. Response id=1 → pending[0] and pending[3] clear in the same cycle; pending[1] stays set.
- **Downstream stall.** `gbar_bus_if.req_ready`=0 for 3 cycles with out_valid=1 → payload is held and all req_ready=0. On release, the next grant goes to rr_ptr's successor without skipping.
- **Same-cycle clear and request.** Response for requester 1's id arrives while requester 1 asserts a new request → no accept that cycle, accept the next cycle. No double pending set.
- **Reset mid-flight.** Reset asserted with 2 pending and out_valid=1 → the next cycle has all outputs 0 and pending=0. The first post-reset grant goes to the lowest valid index.

Source files
------------

// File: rtl/gbar_arbiter_pkg.sv
// Shared widths, bus payload types and helpers for the global barrier arbiter.
package gbar_arbiter_pkg;

    localparam int unsigned GBAR_NB_WIDTH = 4;
    localparam int unsigned GBAR_NC_WIDTH = 5;

    typedef struct packed {
        logic [GBAR_NB_WIDTH-1:0] id;
        logic [GBAR_NC_WIDTH-1:0] size_m1;
        logic [GBAR_NC_WIDTH-1:0] core_id;
    } gbar_req_t;

    typedef struct packed {
        logic [GBAR_NB_WIDTH-1:0] id;
    } gbar_rsp_t;

    // Index following idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/VX_gbar_bus_if.sv
// Request/response bus between the arbiter and the global barrier unit.
interface VX_gbar_bus_if;

    logic                        req_valid;
    gbar_arbiter_pkg::gbar_req_t req_data;
    logic                        req_ready;
    logic                        rsp_valid;
    gbar_arbiter_pkg::gbar_rsp_t rsp_data;

    modport master (
        output req_valid, req_data,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/gbar_arbiter_rr.sv
// Round-robin grant with one-hot output; the pointer moves past the winner
// only when the caller reports the grant as taken via advance.
module gbar_rr_arbiter import gbar_arbiter_pkg::*; #(
    parameter  int unsigned NUM_REQS = 4,
    localparam int unsigned IDX_W    = $clog2(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] requests,
    input  logic                advance,
    output logic [NUM_REQS-1:0] grant_onehot,
    output logic [IDX_W-1:0]    grant_index,
    output logic                grant_valid
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        int unsigned cand;
        grant_onehot = '0;
        grant_index  = '0;
        grant_valid  = 1'b0;
        cand         = 0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            cand = (32'(ptr_q) + k) % NUM_REQS;
            if (!grant_valid && requests[cand]) begin
                grant_valid        = 1'b1;
                grant_onehot[cand] = 1'b1;
                grant_index        = IDX_W'(cand);
            end
        end

        ptr_d = ptr_q;
        if (advance && grant_valid) begin
            ptr_d = IDX_W'(rr_next(32'(grant_index), NUM_REQS));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/gbar_arbiter.sv
// Global barrier front-end: round-robin request funnel into the barrier unit,
// registered release broadcast, and per-requester single-outstanding tracking.
module gbar_arbiter import gbar_arbiter_pkg::*; #(
    parameter int unsigned NUM_REQS = 4,
    parameter int unsigned NB_WIDTH = GBAR_NB_WIDTH,
    parameter int unsigned NC_WIDTH = GBAR_NC_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req_valid,
    input  logic [NB_WIDTH-1:0] req_id      [NUM_REQS],
    input  logic [NC_WIDTH-1:0] req_size_m1 [NUM_REQS],
    input  logic [NC_WIDTH-1:0] req_core_id [NUM_REQS],
    output logic [NUM_REQS-1:0] req_ready,
    output logic                rsp_valid,
    output logic [NB_WIDTH-1:0] rsp_id,
    VX_gbar_bus_if.master       gbar_bus_if
);

    localparam int unsigned IDX_W = $clog2(NUM_REQS);

    logic [NUM_REQS-1:0] pending_q, pending_d;
    logic [NB_WIDTH-1:0] pending_id_q [NUM_REQS];
    logic [NB_WIDTH-1:0] pending_id_d [NUM_REQS];
    logic [NUM_REQS-1:0] eligible, grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_valid, accept;
    logic                out_valid_q, out_valid_d;
    gbar_req_t           out_req_q, out_req_d;
    logic                rsp_valid_q;
    logic [NB_WIDTH-1:0] rsp_id_q;

    assign eligible = req_valid & ~pending_q;
    assign accept   = grant_valid && (!out_valid_q || gbar_bus_if.req_ready) && !reset;

    gbar_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_rr (
        .clk          (clk),
        .reset        (reset),
        .requests     (eligible),
        .advance      (accept),
        .grant_onehot (grant),
        .grant_index  (grant_idx),
        .grant_valid  (grant_valid)
    );

    assign req_ready = accept ? grant : '0;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_req_d    = out_req_q;
        pending_d    = pending_q;
        pending_id_d = pending_id_q;

        if (accept) begin
            out_valid_d       = 1'b1;
            out_req_d.id      = req_id[grant_idx];
            out_req_d.size_m1 = req_size_m1[grant_idx];
            out_req_d.core_id = req_core_id[grant_idx];
        end else if (gbar_bus_if.req_ready) begin
            out_valid_d = 1'b0;
        end

        // Set needs !pending and clear needs pending, so the two never collide on one requester.
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (accept && grant[i]) begin
                pending_d[i]    = 1'b1;
                pending_id_d[i] = req_id[i];
            end else if (rsp_valid_q && pending_q[i] && (pending_id_q[i] == rsp_id_q)) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            rsp_valid_q <= gbar_bus_if.rsp_valid;
            rsp_id_q    <= gbar_bus_if.rsp_data.id;
        end
    end

    // NOTE: payload registers carry no reset; they are only observed when their valid bit is set.
    always_ff @(posedge clk) begin
        out_req_q    <= out_req_d;
        pending_id_q <= pending_id_d;
    end

    assign gbar_bus_if.req_valid = out_valid_q;
    assign gbar_bus_if.req_data  = out_req_q;
    assign rsp_valid             = rsp_valid_q;
    assign rsp_id                = rsp_id_q;

endmodule

// File: tb/tb_gbar_arbiter.sv
// Directed bench for gbar_arbiter: fairness, pending block/release, multi-clear,
// downstream stall, same-cycle clear/request and reset mid-flight.
module tb_gbar_arbiter;
    import gbar_arbiter_pkg::*;

    localparam int unsigned N = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [N-1:0]             req_valid;
    logic [GBAR_NB_WIDTH-1:0] req_id      [N];
    logic [GBAR_NC_WIDTH-1:0] req_size_m1 [N];
    logic [GBAR_NC_WIDTH-1:0] req_core_id [N];
    logic [N-1:0]             req_ready;
    logic                     rsp_valid;
    logic [GBAR_NB_WIDTH-1:0] rsp_id;

    VX_gbar_bus_if bus ();

    gbar_arbiter #(.NUM_REQS(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_id      (req_id),
        .req_size_m1 (req_size_m1),
        .req_core_id (req_core_id),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .gbar_bus_if (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            req_id[i]      = '0;
            req_size_m1[i] = '0;
            req_core_id[i] = '0;
        end
        bus.req_ready = 1'b1;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
    endtask

    // Leaves the bench at the start of the first cycle with reset released.
    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got 0x0, expected 0x1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        do_reset();
        settle();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_out_valid", 32'(bus.req_valid), 32'h0);
        check("rst_pending", 32'(dut.pending_q), 32'h0);

        // Round-robin fairness: grants 0,1,2,3; downstream valid in cycles 1..4
        for (int i = 0; i < N; i++) begin
            req_id[i]      = GBAR_NB_WIDTH'(i);
            req_size_m1[i] = GBAR_NC_WIDTH'(i + 1);
            req_core_id[i] = GBAR_NC_WIDTH'(i + 8);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            settle();
            check("rr_ready", 32'(req_ready), (c < 4) ? (32'h1 << c) : 32'h0);
            check("rr_out_valid", 32'(bus.req_valid), (c >= 1 && c <= 4) ? 32'h1 : 32'h0);
            if (c >= 1 && c <= 4) begin
                check("rr_out_id", 32'(bus.req_data.id), 32'(c - 1));
                check("rr_out_size", 32'(bus.req_data.size_m1), 32'(c));
                check("rr_out_core", 32'(bus.req_data.core_id), 32'(c + 7));
            end
        end

        // Pending block and release on id 5
        do_reset();
        req_valid = 4'b0100;
        req_id[2] = 4'd5;
        settle();
        check("pb_accept", 32'(req_ready), 32'h4);
        step(); settle();
        check("pb_block1", 32'(req_ready), 32'h0);
        check("pb_out_valid", 32'(bus.req_valid), 32'h1);
        check("pb_out_id", 32'(bus.req_data.id), 32'h5);
        step(); settle();
        check("pb_block2", 32'(req_ready), 32'h0);
        check("pb_out_drain", 32'(bus.req_valid), 32'h0);
        step();
        bus.rsp_valid    = 1'b1;
        bus.rsp_data.id  = 4'd5;
        settle();
        check("pb_block_m", 32'(req_ready), 32'h0);
        check("pb_rsp_m", 32'(rsp_valid), 32'h0);
        step();
        bus.rsp_valid = 1'b0;
        settle();
        check("pb_rsp_m1", 32'(rsp_valid), 32'h1);
        check("pb_rsp_id_m1", 32'(rsp_id), 32'h5);
        check("pb_block_m1", 32'(req_ready), 32'h0);
        step(); settle();
        check("pb_reaccept_m2", 32'(req_ready), 32'h4);

        // Multi-clear: 0 and 3 pending on id 1, 1 pending on id 2
        do_reset();
        req_id[0] = 4'd1;
        req_id[1] = 4'd2;
        req_id[3] = 4'd1;
        req_valid = 4'b1011;
        settle();
        check("mc_grant0", 32'(req_ready), 32'h1);
        step(); settle();
        check("mc_grant1", 32'(req_ready), 32'h2);
        step(); settle();
        check("mc_grant3", 32'(req_ready), 32'h8);
        step();
        req_valid       = '0;
        bus.rsp_valid   = 1'b1;
        bus.rsp_data.id = 4'd1;
        settle();
        check("mc_pending_m", 32'(dut.pending_q), 32'hB);
        step();
        bus.rsp_valid = 1'b0;
        settle();
        check("mc_rsp_valid", 32'(rsp_valid), 32'h1);
        check("mc_rsp_id", 32'(rsp_id), 32'h1);
        check("mc_pending_m1", 32'(dut.pending_q), 32'hB);
        step(); settle();
        check("mc_pending_m2", 32'(dut.pending_q), 32'h2);
        req_valid = 4'b1011;
        settle();
        check("mc_regrant0", 32'(req_ready), 32'h1);
        step(); settle();
        check("mc_regrant3", 32'(req_ready), 32'h8);

        // Downstream stall for 3 cycles, then resume at pointer successor
        do_reset();
        for (int i = 0; i < N; i++) req_id[i] = GBAR_NB_WIDTH'(i + 7);
        req_valid = 4'b1111;
        settle();
        check("st_grant0", 32'(req_ready), 32'h1);
        for (int c = 1; c <= 3; c++) begin
            step();
            bus.req_ready = 1'b0;
            settle();
            check("st_ready_low", 32'(req_ready), 32'h0);
            check("st_out_valid", 32'(bus.req_valid), 32'h1);
            check("st_out_hold", 32'(bus.req_data.id), 32'h7);
        end
        step();
        bus.req_ready = 1'b1;
        settle();
        check("st_resume_grant", 32'(req_ready), 32'h2);
        check("st_resume_id", 32'(bus.req_data.id), 32'h7);
        step(); settle();
        check("st_next_id", 32'(bus.req_data.id), 32'h8);
        check("st_next_grant", 32'(req_ready), 32'h4);

        // Same-cycle clear and re-request on requester 1
        do_reset();
        req_id[1] = 4'd9;
        req_valid = 4'b0010;
        settle();
        check("sc_accept", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        settle();
        step();
        bus.rsp_valid   = 1'b1;
        bus.rsp_data.id = 4'd9;
        settle();
        step();
        bus.rsp_valid = 1'b0;
        req_id[1]     = 4'd10;
        req_valid     = 4'b0010;
        settle();
        check("sc_rsp_valid", 32'(rsp_valid), 32'h1);
        check("sc_no_accept", 32'(req_ready), 32'h0);
        step(); settle();
        check("sc_accept_next", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        settle();
        check("sc_pending_once", 32'(dut.pending_q), 32'h2);
        check("sc_out_id", 32'(bus.req_data.id), 32'hA);
        check("sc_ready_idle", 32'(req_ready), 32'h0);

        // Reset mid-flight with two pending and a stalled output
        do_reset();
        req_id[0] = 4'd1;
        req_id[1] = 4'd2;
        req_valid = 4'b0011;
        settle();
        check("rm_grant0", 32'(req_ready), 32'h1);
        step();
        bus.rsp_valid   = 1'b1;
        bus.rsp_data.id = 4'd3;
        settle();
        check("rm_grant1", 32'(req_ready), 32'h2);
        step();
        bus.rsp_valid = 1'b0;
        bus.req_ready = 1'b0;
        settle();
        check("rm_orphan_rsp", 32'(rsp_valid), 32'h1);
        check("rm_orphan_id", 32'(rsp_id), 32'h3);
        check("rm_pending_pre", 32'(dut.pending_q), 32'h3);
        check("rm_out_pre", 32'(bus.req_valid), 32'h1);
        reset     = 1'b1;
        req_valid = '0;
        step();
        reset = 1'b0;
        settle();
        check("rm_req_ready", 32'(req_ready), 32'h0);
        check("rm_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rm_rsp_id", 32'(rsp_id), 32'h0);
        check("rm_out_valid", 32'(bus.req_valid), 32'h0);
        check("rm_pending", 32'(dut.pending_q), 32'h0);
        step();
        bus.req_ready = 1'b1;
        req_valid     = 4'b0110;
        settle();
        check("rm_first_grant", 32'(req_ready), 32'h2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
